// File: rtl/cursor_nav_pkg.sv
// Shared types for the cursor navigator: direction FSM states, the
// direction encoding carried on move_dir, and the press-priority helper.
package cursor_nav_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2,
      HOLD   = 2'd3
   } nav_state_t;

   typedef logic [1:0] dir_t;

   // The encoding doubles as the index of the button in the press vector
   localparam dir_t DIR_UP    = 2'b00;
   localparam dir_t DIR_DOWN  = 2'b01;
   localparam dir_t DIR_LEFT  = 2'b10;
   localparam dir_t DIR_RIGHT = 2'b11;

   // Resolve simultaneous press events: up > down > left > right
   function automatic dir_t prio_dir(input logic [3:0] ev);
      if (ev[0]) return DIR_UP;
      if (ev[1]) return DIR_DOWN;
      if (ev[2]) return DIR_LEFT;
      return DIR_RIGHT;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button front end: 2-FF synchroniser, counting debouncer and a
// single-cycle registered press event on the debounced rising edge.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 330000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic level,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          meta;
   logic          sync;
   logic          level_q;
   logic [CW-1:0] cnt;

   // Two-flop synchroniser for the asynchronous raw button
   // NOTE: reset is sampled on the clock edge, and all state uses <= so every
   // flop sees pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         sync <= 1'b0;
      end else begin
         meta <= btn;
         sync <= meta;
      end
   end

   // Accept a level change only after DEBOUNCE_CYCLES disagreeing samples in a row
   always_ff @(posedge clk) begin
      if (rst) begin
         level <= 1'b0;
         cnt   <= '0;
      end else if (sync == level) begin
         cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
         level <= sync;
         cnt   <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   // Registered one-cycle press event on the debounced rising edge
   always_ff @(posedge clk) begin
      if (rst) begin
         level_q <= 1'b0;
         press   <= 1'b0;
      end else begin
         level_q <= level;
         press   <= level & ~level_q;
      end
   end

endmodule

// File: rtl/cursor_nav.sv
// Cursor navigator: debounces five buttons, runs the direction/auto-repeat
// FSM and moves a cursor over a COLS x ROWS grid with wrap or saturation.
module cursor_nav
   import cursor_nav_pkg::*;
#(
   parameter int COLS            = 4,
   parameter int ROWS            = 5,
   parameter int DEBOUNCE_CYCLES = 330000,
   parameter int REPEAT_EN       = 1,
   parameter int REPEAT_DELAY    = 16500000,
   parameter int REPEAT_RATE     = 4950000,
   parameter int WRAP            = 1,
   localparam int XW = ($clog2(COLS) > 1) ? $clog2(COLS) : 1,
   localparam int YW = ($clog2(ROWS) > 1) ? $clog2(ROWS) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          btn_up,
   input  logic          btn_down,
   input  logic          btn_left,
   input  logic          btn_right,
   input  logic          btn_sel,
   output logic [XW-1:0] cursor_x,
   output logic [YW-1:0] cursor_y,
   output logic          move_pulse,
   output logic [1:0]    move_dir,
   output logic          sel_pulse
);

   localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int TW   = $clog2(TMAX) + 1;
   localparam logic [XW-1:0] X_MAX = XW'(COLS - 1);
   localparam logic [YW-1:0] Y_MAX = YW'(ROWS - 1);

   // Bit order matches the direction encoding; bit 4 is select
   logic [4:0] raw_btn;
   logic [4:0] lvl;
   logic [4:0] prs;
   logic       unused_sel_level;

   nav_state_t    state, state_nxt;
   dir_t          hold_dir, hold_dir_nxt;
   logic [TW-1:0] timer, timer_nxt;
   logic          step;
   logic [XW-1:0] x_nxt;
   logic [YW-1:0] y_nxt;
   logic          moved;

   assign raw_btn          = {btn_sel, btn_right, btn_left, btn_down, btn_up};
   assign unused_sel_level = lvl[4];

   for (genvar i = 0; i < 5; i++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_btn (
         .clk  (clk),
         .rst  (rst),
         .btn  (raw_btn[i]),
         .level(lvl[i]),
         .press(prs[i])
      );
   end

   // Direction FSM state, latched direction and repeat timer
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         hold_dir <= DIR_UP;
         timer    <= '0;
      end else begin
         state    <= state_nxt;
         hold_dir <= hold_dir_nxt;
         timer    <= timer_nxt;
      end
   end

   // Next state: start on a press event, time the repeat, leave on release
   // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
   always_comb begin
      state_nxt    = state;
      hold_dir_nxt = hold_dir;
      timer_nxt    = timer;
      step         = 1'b0;
      case (state)
         IDLE: begin
            if (|prs[3:0]) begin
               hold_dir_nxt = prio_dir(prs[3:0]);
               step         = 1'b1;
               timer_nxt    = '0;
               state_nxt    = (REPEAT_EN != 0) ? DELAY : HOLD;
            end
         end
         DELAY: begin
            if (!lvl[hold_dir]) begin
               state_nxt = IDLE;
               timer_nxt = '0;
            end else if (timer == TW'(REPEAT_DELAY - 1)) begin
               step      = 1'b1;
               timer_nxt = '0;
               state_nxt = REPEAT;
            end else begin
               timer_nxt = timer + TW'(1);
            end
         end
         REPEAT: begin
            if (!lvl[hold_dir]) begin
               state_nxt = IDLE;
               timer_nxt = '0;
            end else if (timer == TW'(REPEAT_RATE - 1)) begin
               step      = 1'b1;
               timer_nxt = '0;
            end else begin
               timer_nxt = timer + TW'(1);
            end
         end
         HOLD: begin
            if (!lvl[hold_dir]) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Move arithmetic: wrap or saturate at the grid edges
   always_comb begin
      x_nxt = cursor_x;
      y_nxt = cursor_y;
      moved = 1'b0;
      if (step) begin
         case (hold_dir_nxt)
            DIR_UP: begin
               if (cursor_y != '0) begin
                  y_nxt = cursor_y - YW'(1);
                  moved = 1'b1;
               end else if (WRAP != 0) begin
                  y_nxt = Y_MAX;
                  moved = 1'b1;
               end
            end
            DIR_DOWN: begin
               if (cursor_y != Y_MAX) begin
                  y_nxt = cursor_y + YW'(1);
                  moved = 1'b1;
               end else if (WRAP != 0) begin
                  y_nxt = '0;
                  moved = 1'b1;
               end
            end
            DIR_LEFT: begin
               if (cursor_x != '0) begin
                  x_nxt = cursor_x - XW'(1);
                  moved = 1'b1;
               end else if (WRAP != 0) begin
                  x_nxt = X_MAX;
                  moved = 1'b1;
               end
            end
            default: begin
               if (cursor_x != X_MAX) begin
                  x_nxt = cursor_x + XW'(1);
                  moved = 1'b1;
               end else if (WRAP != 0) begin
                  x_nxt = '0;
                  moved = 1'b1;
               end
            end
         endcase
      end
   end

   // Registered outputs: cursor and strobes change on the same edge
   always_ff @(posedge clk) begin
      if (rst) begin
         cursor_x   <= '0;
         cursor_y   <= '0;
         move_pulse <= 1'b0;
         move_dir   <= DIR_UP;
         sel_pulse  <= 1'b0;
      end else begin
         cursor_x   <= x_nxt;
         cursor_y   <= y_nxt;
         move_pulse <= moved;
         if (moved) begin
            move_dir <= hold_dir_nxt;
         end
         sel_pulse  <= prs[4];
      end
   end

endmodule

// File: doc/cursor_nav.md
# cursor_nav

Parametrised cursor navigator for the calculator/POS LCD front end, the next generation of the fixed-grid `cursor_ctrl`. It synchronises and debounces five raw push-buttons (four directions plus select). It moves a cursor over a configurable COLS×ROWS key grid, with optional wrap-around and hold-to-auto-repeat. It sits between the board buttons and `lcd_pic`, in the `lcd_clk_33m` domain, and emits one-cycle move/select strobes for the key-decode logic.

## Interface
- COLS, default 4: grid columns, ≥2
- ROWS, default 5: grid rows, ≥2
- DEBOUNCE_CYCLES, default 330000: consecutive stable cycles required to accept a level change (≈10 ms at 33 MHz)
- REPEAT_EN, default 1: 1 enables auto-repeat while a direction is held
- REPEAT_DELAY, default 16500000: cycles from the first move to the first repeat
- REPEAT_RATE, default 4950000: cycles between subsequent repeats
- WRAP, default 1: 1 wraps at grid edges, 0 saturates
- clk  in  1  single clock (lcd_clk_33m); all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- btn_up, btn_down, btn_left, btn_right, btn_sel  in  1 each  raw, asynchronous, active-high
- cursor_x  out  XW=max(1,$clog2(COLS))  column, 0 = left
- cursor_y  out  YW=max(1,$clog2(ROWS))  row, 0 = top
- move_pulse  out  1  one-cycle strobe coincident with each cursor change
- move_dir  out  2  direction of the last accepted move: 00 up, 01 down, 10 left, 11 right
- sel_pulse  out  1  one-cycle strobe per debounced select press

## Operation
- Each button passes through a 2-FF synchroniser, then a debouncer.
  - The debounced level flips only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any agreeing sample clears the counter.
- Press event: debounced rising edge, one cycle.
- sel_pulse fires on the btn_sel press event only. It never repeats and is independent of the direction FSM.
- Direction FSM states:
  - IDLE: on any direction press event, latch the direction, perform a move, go to DELAY (or HOLD if REPEAT_EN=0).
  - DELAY: count REPEAT_DELAY cycles, then move and go to REPEAT.
  - REPEAT: move every REPEAT_RATE cycles.
  - HOLD: wait for release.
  - In DELAY, REPEAT and HOLD, release of the latched button (debounced low) returns to IDLE and clears the timer.
- Simultaneous press events in one cycle: priority up > down > left > right. Losers are dropped, not queued.
- Other directions pressed while not in IDLE are ignored. They take effect only if they produce a new press event after the FSM returns to IDLE.
- Move arithmetic:
  - up: y−1
  - down: y+1
  - left: x−1
  - right: x+1
- Edge behaviour:
  - WRAP=1: 0−1 → max, max+1 → 0.
  - WRAP=0: the coordinate holds, move_pulse stays 0, and move_dir is not updated. Repeat timing continues.
- move_dir updates only with move_pulse.

## Timing
- Reset values:
  - cursor_x = 0, cursor_y = 0
  - move_pulse = 0, sel_pulse = 0, move_dir = 00
  - FSM = IDLE, all debounced levels = 0, all counters = 0
- Latency: a raw level stable from clock edge k yields move_pulse/sel_pulse and the new cursor on edge k+DEBOUNCE_CYCLES+3. Cursor and strobe change on the same edge.
- Repeat spacing: the first repeat comes exactly REPEAT_DELAY cycles after the initial move_pulse. Later repeats are exactly REPEAT_RATE cycles apart.
- Release latency: DEBOUNCE_CYCLES+2 cycles. A repeat due before the debounced release still occurs.
- Reset mid-operation: all state returns to reset values. A button still held after reset debounces as a fresh press and moves once.

## Structure
- Package cursor_nav_pkg:
  - FSM state enum (IDLE, DELAY, REPEAT, HOLD)
  - direction encoding constants DIR_UP/DOWN/LEFT/RIGHT
- Sub-module btn_debounce (synchroniser + debouncer + press-event output, parameter DEBOUNCE_CYCLES), instantiated 5×.
- Timer width: $clog2 of max(REPEAT_DELAY, REPEAT_RATE) + 1.

## Test plan
Bench parameters: COLS=4, ROWS=5, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8.
- Reset: assert rst 2 cycles → cursor (0,0), all strobes 0, move_dir 00.
- Glitch rejection: btn_right high 3 cycles then low → no move_pulse, cursor (0,0).
- Single press: btn_right high 10 cycles → exactly one move_pulse, 7 edges after first high sample; cursor_x=1, move_dir=11.
- Saturation and wrap:
  - WRAP=0 at x=3, press right → x stays 3, no move_pulse.
  - WRAP=1 from (0,0), press left then up → (3,4).
- Auto-repeat: from y=0, WRAP=1, hold btn_down until six move_pulses have occurred → pulses at offsets 0, 20, 28, 36, 44, 52; y = 1.
- Priority and reset:
  - btn_up and btn_right rise together from (1,1) → only up taken, cursor (1,0), move_dir=00.
  - rst during REPEAT with btn_down held → (0,0), then one move after 7 cycles.
